// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: req/ack sequencer for a direct-mapped read-only cache: lookup, block refill from RAM, hit/miss stats
// Inputs : req (read request), hit/v (tag compare and line valid), clr_stats (zero both counters)
// Outputs: ack (byte ready), busy, addr_latch (capture request address),
//          ram_rd/ram_blk (RAM read strobe and block offset), data_wr/wr_blk (data cache write),
//          mux_sel (data cache index from wr_blk), tag_wr (write tag, set valid), hit_count, miss_count
module cache_refill_ctrl #(
  parameter int BLK_BITS = 3,
  parameter int RAM_LAT  = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                hit,
  input  logic                v,
  input  logic                clr_stats,
  output logic                ack,
  output logic                busy,
  output logic                addr_latch,
  output logic                ram_rd,
  output logic [BLK_BITS-1:0] ram_blk,
  output logic                data_wr,
  output logic [BLK_BITS-1:0] wr_blk,
  output logic                mux_sel,
  output logic                tag_wr,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count
);
  localparam int N  = 1 << BLK_BITS;
  localparam int KW = BLK_BITS + 3;
  localparam logic [KW-1:0] K_LAST = KW'(N + RAM_LAT - 1);
  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_t;
  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [CNT_W-1:0]  hit_q, hit_d, miss_q, miss_d;
  logic              in_fill, lookup_hit, lookup_miss;
  always_comb begin
    in_fill     = state_q == FILL;
    lookup_hit  = state_q == LOOKUP && hit && v;
    lookup_miss = state_q == LOOKUP && !(hit && v);
    state_d     = state_q == IDLE   ? (req ? LOOKUP : IDLE) :
                  state_q == LOOKUP ? (hit && v ? RESP : FILL) :
                  state_q == FILL   ? (k_q == K_LAST ? RESP : FILL) : IDLE;
    // k idles at zero so the first FILL cycle is k = 0
    k_d         = in_fill && k_q != K_LAST ? k_q + KW'(1) : '0;
    hit_d       = clr_stats ? '0 : lookup_hit && hit_q != '1 ? hit_q + CNT_W'(1) : hit_q;
    miss_d      = clr_stats ? '0 : lookup_miss && miss_q != '1 ? miss_q + CNT_W'(1) : miss_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end
  // strobes decode from state and k only; addr_latch alone follows req, to capture the address in the sample cycle
  assign ack        = state_q == RESP;
  assign busy       = state_q != IDLE;
  assign addr_latch = state_q == IDLE && req;
  assign mux_sel    = in_fill;
  assign ram_rd     = in_fill && k_q < KW'(N);
  assign ram_blk    = ram_rd ? k_q[BLK_BITS-1:0] : '0;
  assign data_wr    = in_fill && k_q >= KW'(RAM_LAT);
  assign wr_blk     = data_wr ? BLK_BITS'(k_q - KW'(RAM_LAT)) : '0;
  assign tag_wr     = in_fill && k_q == K_LAST;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: vector table and scoreboard checks for cache_refill_ctrl at default, RAM_LAT=3 and CNT_W=2
module tb_cache_refill_ctrl;
  localparam int N = 8;
  localparam int L = 1;
  typedef struct {
    bit rst, req, hit, v, clr, chk;
    bit ack, busy, al, rd, wr, tw, ms;
    bit [2:0] rblk, wblk;
    int hc, mc, hc2, mc2;
  } vec_t;
  logic clk = 0, reset = 1, req = 0, hit = 0, v = 0, clr_stats = 0, req1 = 0, hit1 = 0, v1 = 0;
  logic ack0, busy0, al0, rd0, wr0, ms0, tw0;
  logic [2:0] rblk0, wblk0;
  logic [15:0] hc0, mc0;
  logic ack1, busy1, al1, rd1, wr1, ms1, tw1;
  logic [2:0] rblk1, wblk1;
  logic [15:0] hcnt1, mcnt1;
  logic ack2, busy2, al2, rd2, wr2, ms2, tw2;
  logic [2:0] rblk2, wblk2;
  logic [1:0] hcnt2, mcnt2;
  int errors = 0, checks = 0;
  int hc = 0, mc = 0, hc2 = 0, mc2 = 0;
  vec_t tbl[$];
  vec_t sb[$];
  always #5 clk = ~clk;
  cache_refill_ctrl dut0 (
    .clk(clk), .reset(reset), .req(req), .hit(hit), .v(v), .clr_stats(clr_stats),
    .ack(ack0), .busy(busy0), .addr_latch(al0), .ram_rd(rd0), .ram_blk(rblk0), .data_wr(wr0),
    .wr_blk(wblk0), .mux_sel(ms0), .tag_wr(tw0), .hit_count(hc0), .miss_count(mc0));
  cache_refill_ctrl #(.RAM_LAT(3)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .hit(hit1), .v(v1), .clr_stats(clr_stats),
    .ack(ack1), .busy(busy1), .addr_latch(al1), .ram_rd(rd1), .ram_blk(rblk1), .data_wr(wr1),
    .wr_blk(wblk1), .mux_sel(ms1), .tag_wr(tw1), .hit_count(hcnt1), .miss_count(mcnt1));
  cache_refill_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .req(req), .hit(hit), .v(v), .clr_stats(clr_stats),
    .ack(ack2), .busy(busy2), .addr_latch(al2), .ram_rd(rd2), .ram_blk(rblk2), .data_wr(wr2),
    .wr_blk(wblk2), .mux_sel(ms2), .tag_wr(tw2), .hit_count(hcnt2), .miss_count(mcnt2));
  function automatic vec_t base(bit rq, bit h, bit vv);
    vec_t r = '{default: 0};
    r.req = rq; r.hit = h; r.v = vv; r.chk = 1;
    r.hc = hc; r.mc = mc; r.hc2 = hc2; r.mc2 = mc2;
    return r;
  endfunction
  function automatic int sat3(int x);
    return x > 3 ? 3 : x;
  endfunction
  task automatic zero_counts();
    hc = 0; mc = 0; hc2 = 0; mc2 = 0;
  endtask
  task automatic idle(int n);
    repeat (n) tbl.push_back(base(0, 0, 0));
  endtask
  task automatic rst_cyc(int n);
    vec_t r;
    repeat (n) begin
      r = base(0, 0, 0); r.rst = 1; r.chk = 0;
      tbl.push_back(r);
      zero_counts();
    end
  endtask
  task automatic hit_txn(bit hold, bit clr);
    vec_t r;
    r = base(1, 0, 0); r.al = 1; tbl.push_back(r);
    r = base(hold, 1, 1); r.busy = 1; r.clr = clr; tbl.push_back(r);
    if (clr) zero_counts();
    else begin hc++; hc2 = sat3(hc2 + 1); end
    r = base(hold, 0, 0); r.ack = 1; r.busy = 1; tbl.push_back(r);
  endtask
  task automatic miss_txn(bit h, bit vv, int abort_k);
    vec_t r;
    r = base(1, 0, 0); r.al = 1; tbl.push_back(r);
    r = base(0, h, vv); r.busy = 1; tbl.push_back(r);
    mc++; mc2 = sat3(mc2 + 1);
    for (int k = 0; k < N + L; k++) begin
      r = base(0, 0, 0); r.busy = 1; r.ms = 1;
      r.rd = k < N; r.rblk = k < N ? 3'(k) : 3'd0;
      r.wr = k >= L; r.wblk = k >= L ? 3'(k - L) : 3'd0;
      r.tw = k == N + L - 1;
      if (k == abort_k) begin
        r.rst = 1; tbl.push_back(r); zero_counts();
        return;
      end
      tbl.push_back(r);
    end
    r = base(0, 0, 0); r.ack = 1; r.busy = 1; tbl.push_back(r);
  endtask
  initial begin
    vec_t e;
    logic [10:0] got, exp;
    rst_cyc(2); idle(2);
    hit_txn(0, 0); idle(1);
    miss_txn(0, 0, -1); idle(1);
    miss_txn(0, 1, -1); idle(2);
    miss_txn(0, 0, 4); idle(2);
    miss_txn(0, 0, -1); idle(2);
    for (int i = 0; i < 5; i++) hit_txn(1, 0);
    hit_txn(0, 1); idle(2);
    for (int i = 0; i < 4; i++) begin hit_txn(0, 0); idle(1); end
    idle(1);
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      reset = tbl[i].rst; req = tbl[i].req; hit = tbl[i].hit; v = tbl[i].v; clr_stats = tbl[i].clr;
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      if (e.chk) begin
        checks++;
        got = {ack0, busy0, al0, rd0, rblk0, wr0, wblk0, tw0, ms0} & 11'h7ff;
        got = {ack0, busy0, al0, rd0, rblk0, wr0, wblk0} ;
        exp = {e.ack, e.busy, e.al, e.rd, e.rblk, e.wr, e.wblk};
        if (got !== exp || tw0 !== e.tw || ms0 !== e.ms || hc0 !== 16'(e.hc) || mc0 !== 16'(e.mc) ||
            hcnt2 !== 2'(e.hc2) || mcnt2 !== 2'(e.mc2)) begin
          errors++;
          $display("FAIL vec%0d ack/busy/al/rd/rblk/wr/wblk got=%b exp=%b tw got=%b exp=%b ms got=%b exp=%b hc got=%0d exp=%0d mc got=%0d exp=%0d hc2 got=%0d exp=%0d mc2 got=%0d exp=%0d",
                   i, got, exp, tw0, e.tw, ms0, e.ms, hc0, e.hc, mc0, e.mc, hcnt2, e.hc2, mcnt2, e.mc2);
        end
      end
    end
    for (int c = 0; c < 17; c++) begin
      @(posedge clk); #1;
      reset = 0; req = 0; clr_stats = 0; req1 = c == 0; hit1 = 0; v1 = 1;
      @(negedge clk);
      checks++;
      got = {ack1, busy1, al1, rd1, rblk1, wr1, wblk1};
      exp = {c == 13, c >= 1 && c <= 13, c == 0, c >= 2 && c <= 9, (c >= 2 && c <= 9) ? 3'(c - 2) : 3'd0,
             c >= 5 && c <= 12, (c >= 5 && c <= 12) ? 3'(c - 5) : 3'd0};
      if (got !== exp || tw1 !== (c == 12) || ms1 !== (c >= 2 && c <= 12) || mcnt1 !== ((c >= 2) ? 16'd1 : 16'd0) || hcnt1 !== 16'd0) begin
        errors++;
        $display("FAIL lat3 c%0d ack/busy/al/rd/rblk/wr/wblk got=%b exp=%b tw=%b ms=%b mc=%0d hc=%0d", c, got, exp, tw1, ms1, mcnt1, hcnt1);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Sequencing controller for the direct-mapped read-only cache: tag/valid arrays, data cache, backing RAM, block counter and data mux.
- Accepts one read request at a time from a requester over a req/ack handshake.
- Performs the tag lookup. On a miss, streams a full block from RAM into the data cache, then updates tag/valid.
- Keeps saturating hit and miss statistics.

Parameters:
- BLK_BITS, 3, log2 of bytes per block; block length N = 2^BLK_BITS.
- RAM_LAT, 1, cycles from RAM address/read issue to RAM data valid; legal range 1..4.
- CNT_W, 16, width of the hit/miss statistics counters.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- req  in  1  requester read request; sampled only in IDLE
- hit  in  1  tag comparator output (stored tag == request tag)
- v  in  1  valid bit of the addressed line
- clr_stats  in  1  synchronous clear of both statistics counters
- ack  out  1  one-cycle pulse: requested byte is on the data cache output
- busy  out  1  high whenever state != IDLE
- addr_latch  out  1  one-cycle enable for the request address register
- ram_rd  out  1  RAM read strobe
- ram_blk  out  BLK_BITS  block-offset address to RAM
- data_wr  out  1  data cache write enable
- wr_blk  out  BLK_BITS  data cache write block index
- mux_sel  out  1  1 = data cache index from wr_blk; 0 = from request block offset
- tag_wr  out  1  write tag array and set valid bit for the addressed line
- hit_count  out  CNT_W  saturating hit counter
- miss_count  out  CNT_W  saturating miss counter

Behaviour:
- Reset (synchronous, active-high): state = IDLE and all outputs 0, including both counters. Reset wins in any state, including mid-FILL; a partial fill is abandoned with no tag_wr.
- States: IDLE, LOOKUP, FILL, RESP.
- IDLE
  - req=1: addr_latch=1 this cycle; next state LOOKUP.
  - Otherwise stay in IDLE.
- LOOKUP (exactly 1 cycle)
  - hit&v: hit_count += 1; next state RESP.
  - Otherwise (tag mismatch or invalid line): miss_count += 1; internal fill counter k = 0; next state FILL.
- FILL (exactly N+RAM_LAT cycles, k = 0..N+RAM_LAT-1)
  - mux_sel = 1 throughout.
  - ram_rd = 1 and ram_blk = k for k < N; otherwise ram_rd = 0 and ram_blk = 0.
  - data_wr = 1 and wr_blk = k-RAM_LAT for k >= RAM_LAT; otherwise data_wr = 0.
  - tag_wr = 1 only at k = N+RAM_LAT-1, coincident with the final data_wr.
  - After the last cycle, next state RESP.
- RESP (exactly 1 cycle)
  - ack = 1, mux_sel = 0; next state IDLE.
- Latency
  - Hit: ack asserted 2 cycles after the req sample cycle.
  - Miss: ack asserted 2+N+RAM_LAT cycles after it; 11 for defaults.
- Handshake
  - req is ignored outside IDLE.
  - If req is still high in the cycle after ack, a new transaction starts.
  - Back-to-back hits therefore sustain one request per 3 cycles.
- Statistics
  - Both counters stop at 2^CNT_W-1 (no wrap).
  - clr_stats zeroes both counters next edge and overrides a same-cycle increment.
  - Reset also clears both counters.
- Outputs are registered or decoded from state only; ack, data_wr, tag_wr and ram_rd have no combinational path from req/hit/v.
- ram_blk and wr_blk never exceed N-1.
- tag_wr asserts exactly once per miss.
- data_wr asserts exactly N times per miss, covering each block index once in ascending order.

Test Plan:
- Reset, then req=1 with hit=1, v=1 -> addr_latch at cycle 0, ack at cycle 2, hit_count=1, no ram_rd/data_wr/tag_wr.
- Req with v=0 (defaults) -> miss_count=1. ram_rd high cycles 2..9 with ram_blk 0..7. data_wr high cycles 3..10 with wr_blk 0..7. tag_wr only at cycle 10. ack at cycle 11.
- RAM_LAT=3, req with hit=0, v=1 -> data_wr high cycles 5..12, tag_wr at 12, ack at 13, busy high cycles 1..13.
- Reset asserted at FILL k=4 -> next cycle IDLE, all outputs 0, no tag_wr seen. A following req with v=0 repeats the full 8-beat fill.
- req held high continuously with hit=v=1 -> ack every 3 cycles. After the 5th ack assert clr_stats in the same cycle as a LOOKUP hit -> hit_count=0.
- CNT_W=2, four hits -> hit_count reads 3 after the 3rd and 4th hits (saturates). miss_count unaffected.
